mux_sel_arbiter: RTL and testbench
==================================

// Module: mux_sel_arbiter
// PURPOSE
// Upstream control stage for the 2:1 data mux (mux_if_else): arbitrates two
// requesters (A, B) and drives the mux select so only the granted source
// reaches the shared output. Round-robin on contention; a grant is held
// across a multi-beat burst until last, request drop, or MAX_BURST beats.
// sel_out connects directly to the mux sel_in (0 = a_in, 1 = b_in).
// PARAMETERS
// MAX_BURST  16  beats allowed per grant before forced release (>=1)
// CNT_W      $clog2(MAX_BURST+1)  localparam, beat counter width
// PORTS
// clk_in        in   1      clock, all logic on posedge
// rst_in        in   1      reset, synchronous, active-high
// req_a_in      in   1      requester A wants / holds the mux
// last_a_in     in   1      A's final beat (valid only with req_a_in)
// req_b_in      in   1      requester B wants / holds the mux
// last_b_in     in   1      B's final beat (valid only with req_b_in)
// gnt_a_out     out  1      A owns the mux
// gnt_b_out     out  1      B owns the mux
// sel_out       out  1      mux select: 0 = A, 1 = B
// busy_out      out  1      a grant is active
// beat_cnt_out  out  CNT_W  beats accepted in current grant
// timeout_out   out  1      1-cycle pulse: grant forced off by MAX_BURST
// BEHAVIOUR
// - One clock, synchronous active-high reset; all outputs registered.
// - Reset values: gnt_a/gnt_b/sel/busy/timeout = 0, beat_cnt = 0, state IDLE,
//   priority pointer = A. Reset mid-burst: all above restored on that edge.
// - States: IDLE, OWN_A, OWN_B. gnt_a/gnt_b never both 1.
// - IDLE: only A req -> OWN_A; only B req -> OWN_B; both -> side at pointer;
//   none -> stay. Grant visible the cycle after req sampled (latency 1).
// - Beat: cycle with gnt_x_out=1 and req_x_in=1; beat_cnt +1 next cycle.
// - Release from OWN_X on a beat with last_x_in=1, or on a beat where
//   beat_cnt_out == MAX_BURST-1 (MAX_BURST-th beat), or when req_x_in=0
//   while granted (abandon, no beat counted).
// - On release: pointer -> other side; if other req high -> OWN_other next
//   cycle (no bubble), else IDLE. Same side never regranted without IDLE.
// - beat_cnt_out cleared to 0 on every new grant and in IDLE; max MAX_BURST-1.
// - timeout_out = 1 for the cycle after a MAX_BURST release with last_x_in=0;
//   last on the MAX_BURST-th beat is normal release, no timeout.
// - sel_out = 0 in OWN_A, 1 in OWN_B; holds previous value in IDLE.
// - busy_out = 1 exactly when gnt_a_out | gnt_b_out.
// - MAX_BURST=1: every beat releases; timeout pulses unless last=1.
// TESTING
// 1 rst_in=1 two cycles, both req high -> all outputs 0; after release, B
//   reqs alone too: A granted first (pointer A) when both held.
// 2 req_a=1 only, last_a on 4th beat -> gnt_a/busy 1 cycle after req,
//   beat_cnt 0,1,2,3, sel_out 0, then IDLE, gnt_a 0, timeout 0.
// 3 both req held, last every 3rd beat -> grants A,B,A,B back-to-back with
//   no IDLE cycle; sel_out toggles 0,1,0,1 at each handover.
// 4 MAX_BURST=16, req_b held, no last, req_a=0 -> release after 16 beats,
//   timeout_out pulse 1 cycle, beat_cnt peaks 15, sel_out stays 1, IDLE.
// 5 OWN_A, req_a drops after 2 beats, req_b=1 -> gnt_a 0 / gnt_b 1 next
//   cycle, beat_cnt 0, timeout_out 0.
// 6 rst_in=1 for 1 cycle mid-burst in OWN_B -> all outputs reset next edge;
//   with both req held after, A is granted (pointer reset to A).

Source files
------------

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin two-requester arbiter with burst hold, driving the 2:1 mux select
module mux_sel_arbiter #(
    parameter int MAX_BURST = 16,
    localparam int CNT_W = $clog2(MAX_BURST + 1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             req_a_in,
    input  logic             last_a_in,
    input  logic             req_b_in,
    input  logic             last_b_in,
    output logic             gnt_a_out,
    output logic             gnt_b_out,
    output logic             sel_out,
    output logic             busy_out,
    output logic [CNT_W-1:0] beat_cnt_out,
    output logic             timeout_out
);
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic ptr_b, ptr_nxt, to_nxt;
    logic req, last, other;
    assign req   = (state == OWN_A) ? req_a_in : req_b_in;
    assign last  = (state == OWN_A) ? last_a_in : last_b_in;
    assign other = (state == OWN_A) ? req_b_in : req_a_in;
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        ptr_nxt   = ptr_b;
        to_nxt    = 1'b0;
        if (state == IDLE)
            state_nxt = (req_a_in && (!req_b_in || !ptr_b)) ? OWN_A : req_b_in ? OWN_B : IDLE;
        else if (req && !last && beat_cnt_out != CNT_MAX)
            cnt_nxt = beat_cnt_out + 1'b1;
        else begin
            // hand over straight to the waiting side so the mux sees no idle bubble
            to_nxt    = req && !last;
            ptr_nxt   = (state == OWN_A);
            state_nxt = !other ? IDLE : (state == OWN_A) ? OWN_B : OWN_A;
        end
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IDLE;
            ptr_b        <= 1'b0;
            gnt_a_out    <= 1'b0;
            gnt_b_out    <= 1'b0;
            sel_out      <= 1'b0;
            busy_out     <= 1'b0;
            beat_cnt_out <= '0;
            timeout_out  <= 1'b0;
        end else begin
            state        <= state_nxt;
            ptr_b        <= ptr_nxt;
            gnt_a_out    <= state_nxt == OWN_A;
            gnt_b_out    <= state_nxt == OWN_B;
            sel_out      <= (state_nxt == OWN_A) ? 1'b0 : (state_nxt == OWN_B) ? 1'b1 : sel_out;
            busy_out     <= state_nxt != IDLE;
            beat_cnt_out <= cnt_nxt;
            timeout_out  <= to_nxt;
        end
    end
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: scoreboard bench comparing the arbiter against a behavioural owner/count model
module tb_mux_sel_arbiter;
    localparam int MB = 16;
    logic clk_in = 1'b0, rst_in = 1'b1;
    logic req_a_in = 1'b0, last_a_in = 1'b0, req_b_in = 1'b0, last_b_in = 1'b0;
    logic gnt_a_out, gnt_b_out, sel_out, busy_out, timeout_out;
    logic [4:0] beat_cnt_out;
    typedef struct packed {
        logic ga, gb, sel, busy, to;
        logic [4:0] cnt;
    } exp_t;
    exp_t q[$];
    int n_chk = 0, n_pass = 0;
    int m_own = 0, m_cnt = 0, m_ptr = 0;
    logic m_sel = 1'b0, m_to = 1'b0;
    int peak = 0, n_to = 0;
    mux_sel_arbiter #(.MAX_BURST(MB)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_a_in(req_a_in), .last_a_in(last_a_in),
        .req_b_in(req_b_in), .last_b_in(last_b_in),
        .gnt_a_out(gnt_a_out), .gnt_b_out(gnt_b_out), .sel_out(sel_out),
        .busy_out(busy_out), .beat_cnt_out(beat_cnt_out), .timeout_out(timeout_out)
    );
    always #5 clk_in = ~clk_in;
    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask
    task automatic model(input logic r, ra, la, rb, lb);
        logic rq, lst, oth;
        if (r) begin
            m_own = 0; m_cnt = 0; m_ptr = 0; m_sel = 1'b0; m_to = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (m_own == 0) begin
            m_cnt = 0;
            if (ra && (!rb || m_ptr == 0)) m_own = 1;
            else if (rb) m_own = 2;
        end else begin
            rq  = (m_own == 1) ? ra : rb;
            lst = (m_own == 1) ? la : lb;
            oth = (m_own == 1) ? rb : ra;
            if (rq && !lst && m_cnt < MB - 1) m_cnt++;
            else begin
                m_to  = rq && !lst;
                m_ptr = (m_own == 1) ? 1 : 0;
                m_own = oth ? 3 - m_own : 0;
                m_cnt = 0;
            end
        end
        if (m_own != 0) m_sel = (m_own == 2);
    endtask
    task automatic step(input logic r, ra, la, rb, lb);
        exp_t e;
        rst_in = r; req_a_in = ra; last_a_in = la; req_b_in = rb; last_b_in = lb;
        model(r, ra, la, rb, lb);
        q.push_back('{ga: m_own == 1, gb: m_own == 2, sel: m_sel, busy: m_own != 0, to: m_to, cnt: 5'(m_cnt)});
        @(posedge clk_in);
        #1;
        e = q.pop_front();
        check("gnt_a", gnt_a_out, e.ga);
        check("gnt_b", gnt_b_out, e.gb);
        check("sel", sel_out, e.sel);
        check("busy", busy_out, e.busy);
        check("beat_cnt", beat_cnt_out, e.cnt);
        check("timeout", timeout_out, e.to);
        if (int'(beat_cnt_out) > peak) peak = int'(beat_cnt_out);
        if (timeout_out) n_to++;
    endtask
    initial begin
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(0, 1, 0, 1, 0);
        check("both_req_a_first", gnt_a_out, 1);
        step(0, 1, 1, 1, 0);
        step(0, 0, 0, 1, 1);
        repeat (2) step(0, 0, 0, 0, 0);
        repeat (4) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        repeat (20) step(0, 1, m_own == 1 && m_cnt == 2, 1, m_own == 2 && m_cnt == 2);
        repeat (2) step(0, 0, 0, 0, 0);
        peak = 0; n_to = 0;
        repeat (18) step(0, 0, 0, 1, 0);
        check("burst_peak", peak, MB - 1);
        check("timeout_pulses", n_to, 1);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        repeat (2) step(0, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check("abandon_to_b", gnt_b_out, 1);
        repeat (2) step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        check("reset_mid_burst", busy_out, 0);
        step(0, 1, 0, 1, 0);
        check("ptr_reset_a", gnt_a_out, 1);
        repeat (300) begin
            logic ra, rb;
            ra = 1'($urandom_range(0, 3) != 0);
            rb = 1'($urandom_range(0, 3) != 0);
            step(1'($urandom_range(0, 60) == 0), ra, ra & 1'($urandom_range(0, 4) == 0),
                 rb, rb & 1'($urandom_range(0, 4) == 0));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
